i2s_rx_frontend: RTL and testbench
==================================

I2S_RX_FRONTEND -- requirements
Module: i2s_rx_frontend

Interface
REQ-001 Parameter DATA_BITS, default 24, sets the serial word width per channel.
REQ-002 Parameter OUT_BITS, default 18, sets the parallel output width.
REQ-003 Port clock, input, 1: single system clock; all flops on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port sck, input, 1: I2S bit clock, asynchronous to clock, at most clock/8.
REQ-006 Port ws, input, 1: I2S word select, asynchronous; 0 = left, 1 = right.
REQ-007 Port sd, input, 1: I2S serial data, asynchronous, MSB first.
REQ-008 Port clken48kHz, input, 1: one-cycle sample-rate enable, shared with the stereo modulator.
REQ-009 Port err_clr, input, 1: synchronous clear of the sticky error flags.
REQ-010 Port LEFTout, output, OUT_BITS, signed: left sample that feeds the modulator LEFTin.
REQ-011 Port RIGHTout, output, OUT_BITS, signed: right sample that feeds the modulator RIGHTin.
REQ-012 Port valid, output, 1: high once the first complete stereo pair has been presented.
REQ-013 Port overrun, output, 1: sticky; a pending pair was overwritten before it was consumed.
REQ-014 Port underrun, output, 1: sticky; clken48kHz found no pending pair after valid was set.
REQ-015 Port frame_err, output, 1: sticky; ws toggled before DATA_BITS bits were received.

Function
REQ-016 sck, ws and sd SHALL each pass through a 2-flop synchronizer.
REQ-017 A rising sck event SHALL be one synchronized 0->1 transition, detected in exactly one clock cycle.
REQ-018 ws and sd SHALL be sampled only on rising sck events.
REQ-019 A ws change is a rising sck event whose sampled ws differs from the previous sampled ws.
REQ-020 The sd bit sampled on a ws-change event is the LSB slot of the previous word and SHALL be ignored.
REQ-021 The FSM SHALL have three states, IDLE, SHIFT and HOLD, and reset SHALL enter IDLE.
REQ-022 IDLE: events are ignored; a ws change SHALL move to SHIFT with the bit counter at 0 and the channel equal to the new ws.
REQ-023 SHIFT: each following rising sck event SHALL shift sd into the word and increment the counter.
REQ-024 SHIFT: after DATA_BITS bits the word SHALL be latched into the left or right holding register and the FSM SHALL enter HOLD.
REQ-025 SHIFT: a ws change before DATA_BITS bits SHALL discard the partial word, set frame_err, and restart SHIFT for the new channel.
REQ-026 HOLD: extra bits SHALL be ignored; a ws change SHALL restart SHIFT.
REQ-027 Latching a right word SHALL set pair_pending; a left word alone SHALL never set it.
REQ-028 If pair_pending is set when a new right word latches and no clken48kHz occurs that cycle, the new pair SHALL replace the pending pair and overrun SHALL set.
REQ-029 On clken48kHz with pair_pending set, the pending pair SHALL be converted and registered to LEFTout/RIGHTout, pair_pending SHALL clear, and valid SHALL set.
REQ-030 Output latency SHALL be 1 clock after that clken48kHz.
REQ-031 On clken48kHz with pair_pending clear, the outputs SHALL hold, and underrun SHALL set if valid is already 1.
REQ-032 If clken48kHz and a right-word latch occur in the same cycle, the old pending pair SHALL transfer to the outputs, the new pair SHALL become pending, and no overrun SHALL be flagged.
REQ-033 Conversion SHALL keep word bits [DATA_BITS-1 : DATA_BITS-OUT_BITS] as the two's-complement result (truncation).
REQ-034 err_clr SHALL clear all sticky flags; an error event in the same cycle SHALL win and set its flag.

Reset
REQ-035 Reset low SHALL asynchronously clear LEFTout, RIGHTout, valid, overrun, underrun, frame_err, pair_pending, the counter, the shift/holding registers and the synchronizers, and SHALL force IDLE.
REQ-036 Reset mid-word SHALL discard that word; capture SHALL resume only after the next ws change following reset release.

Configuration
REQ-037 Macro I2S_RX_ROUND_EN defined: conversion SHALL add 1 at word bit DATA_BITS-OUT_BITS-1 before truncation and saturate at +2^(OUT_BITS-1)-1.
REQ-038 Macro I2S_RX_ROUND_EN undefined: conversion SHALL be pure truncation per REQ-033, with no rounding or saturation logic.

Verification
REQ-039 Left 0x123456, right 0xEDCBAA, then clken48kHz -> LEFTout=0x048D1, RIGHTout=0x3B72E, valid=1 one clock later.
REQ-040 Left 0x7FFFFF, right 0x000020 -> truncate: 0x1FFFF/0x00000; round: 0x1FFFF (saturated)/0x00001.
REQ-041 Right 0xFFFFFF -> truncate 0x3FFFF; round 0x00000.
REQ-042 Two full pairs with no clken48kHz between them -> overrun=1 and outputs show the second pair; err_clr -> overrun=0.
REQ-043 ws toggles after 10 bits -> frame_err=1, partial word dropped, next full pair captured correctly; reset asserted mid-word -> all outputs 0 and FSM IDLE.
REQ-044 Two clken48kHz pulses with no new pair after valid=1 -> underrun=1 and outputs unchanged.

Source files
------------

// File: rtl/i2s_rx_frontend.sv
// I2S receiver front end: synchronizes sck/ws/sd, deserializes left/right words and
// hands complete stereo pairs to the modulator on clken48kHz. Optional rounding: I2S_RX_ROUND_EN.
module i2s_rx_frontend #(
    parameter int DATA_BITS = 24,
    parameter int OUT_BITS  = 18
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sck,
    input  logic                       ws,
    input  logic                       sd,
    input  logic                       clken48kHz,
    input  logic                       err_clr,
    output logic signed [OUT_BITS-1:0] LEFTout,
    output logic signed [OUT_BITS-1:0] RIGHTout,
    output logic                       valid,
    output logic                       overrun,
    output logic                       underrun,
    output logic                       frame_err
);
    // state | meaning
    // IDLE  | waiting for the first ws change after reset
    // SHIFT | collecting DATA_BITS bits of the current channel
    // HOLD  | word complete, ignoring padding slots until ws changes
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

    state_t state, state_nxt;

    logic [1:0] sck_s, ws_s, sd_s;
    logic       sck_q, ws_prev, primed;
    logic       sck_rise, ws_change;

    logic [DATA_BITS-1:0] shreg, word_in, left_hold, pend_left, pend_right;
    logic [CW-1:0]        cnt;
    logic                 chan, pair_pending;
    logic                 start, shift_en, word_done, frame_evt, right_done, left_done;

    function automatic logic signed [OUT_BITS-1:0] conv(input logic [DATA_BITS-1:0] w);
`ifdef I2S_RX_ROUND_EN
        logic [DATA_BITS:0] sum;
        sum = {w[DATA_BITS-1], w} + ((DATA_BITS + 1)'(1) << (DATA_BITS - OUT_BITS - 1));
        // only a positive word can overflow when adding the half-LSB
        if (sum[DATA_BITS] != sum[DATA_BITS-1])
            conv = {1'b0, {(OUT_BITS - 1){1'b1}}};
        else
            conv = sum[DATA_BITS-1 -: OUT_BITS];
`else
        conv = w[DATA_BITS-1 -: OUT_BITS];
`endif
    endfunction

    assign sck_rise   = sck_s[1] & ~sck_q;
    // the first event after reset only learns ws, so a word cut by reset is never resumed
    assign ws_change  = sck_rise & primed & (ws_s[1] != ws_prev);
    assign word_in    = {shreg[DATA_BITS-2:0], sd_s[1]};
    assign right_done = word_done & chan;
    assign left_done  = word_done & ~chan;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sck_s   <= '0;
            ws_s    <= '0;
            sd_s    <= '0;
            sck_q   <= 1'b0;
            ws_prev <= 1'b0;
            primed  <= 1'b0;
        end else begin
            sck_s <= {sck_s[0], sck};
            ws_s  <= {ws_s[0], ws};
            sd_s  <= {sd_s[0], sd};
            sck_q <= sck_s[1];
            if (sck_rise) begin
                ws_prev <= ws_s[1];
                primed  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift_en  = 1'b0;
        word_done = 1'b0;
        frame_evt = 1'b0;
        case (state)
            IDLE: if (ws_change) begin
                state_nxt = SHIFT;
                start     = 1'b1;
            end
            SHIFT: if (ws_change) begin
                start     = 1'b1;
                frame_evt = 1'b1;
            end else if (sck_rise) begin
                shift_en = 1'b1;
                if (cnt == LAST) begin
                    word_done = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: if (ws_change) begin
                state_nxt = SHIFT;
                start     = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg     <= '0;
            cnt       <= '0;
            chan      <= 1'b0;
            left_hold <= '0;
        end else begin
            if (start) begin
                shreg <= '0;
                cnt   <= '0;
                chan  <= ws_s[1];
            end else if (shift_en) begin
                shreg <= word_in;
                cnt   <= cnt + 1'b1;
            end
            if (left_done) left_hold <= word_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_left    <= '0;
            pend_right   <= '0;
            pair_pending <= 1'b0;
            LEFTout      <= '0;
            RIGHTout     <= '0;
            valid        <= 1'b0;
            overrun      <= 1'b0;
            underrun     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (right_done) begin
                pend_left  <= left_hold;
                pend_right <= word_in;
            end
            if (clken48kHz && pair_pending) begin
                LEFTout  <= conv(pend_left);
                RIGHTout <= conv(pend_right);
                valid    <= 1'b1;
            end
            if (right_done)      pair_pending <= 1'b1;
            else if (clken48kHz) pair_pending <= 1'b0;
            overrun   <= (right_done & pair_pending & ~clken48kHz) | (overrun & ~err_clr);
            underrun  <= (clken48kHz & ~pair_pending & valid) | (underrun & ~err_clr);
            frame_err <= frame_evt | (frame_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Directed bench for i2s_rx_frontend: serial pairs in, converted pairs and sticky flags checked.
module tb_i2s_rx_frontend;
    localparam int DB = 24;
    localparam int OB = 18;

`ifdef I2S_RX_ROUND_EN
    localparam logic [31:0] EXP_R1 = 32'h3B72F;
    localparam logic [31:0] EXP_R2 = 32'h00001;
    localparam logic [31:0] EXP_R3 = 32'h00000;
`else
    localparam logic [31:0] EXP_R1 = 32'h3B72E;
    localparam logic [31:0] EXP_R2 = 32'h00000;
    localparam logic [31:0] EXP_R3 = 32'h3FFFF;
`endif

    logic clock = 1'b0, reset = 1'b0, sck = 1'b0, ws = 1'b0, sd = 1'b0;
    logic clken48kHz = 1'b0, err_clr = 1'b0;
    logic signed [OB-1:0] LEFTout, RIGHTout;
    logic valid, overrun, underrun, frame_err;
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    i2s_rx_frontend #(.DATA_BITS(DB), .OUT_BITS(OB)) dut (
        .clock(clock), .reset(reset), .sck(sck), .ws(ws), .sd(sd),
        .clken48kHz(clken48kHz), .err_clr(err_clr),
        .LEFTout(LEFTout), .RIGHTout(RIGHTout), .valid(valid),
        .overrun(overrun), .underrun(underrun), .frame_err(frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp_l, input logic [31:0] exp_r);
        check({tag, "_left"}, {14'd0, LEFTout}, exp_l);
        check({tag, "_right"}, {14'd0, RIGHTout}, exp_r);
    endtask

    task automatic send_slot(input logic w, input logic d);
        ws = w;
        sd = d;
        repeat (5) @(negedge clock);
        sck = 1'b1;
        repeat (5) @(negedge clock);
        sck = 1'b0;
    endtask

    // ws-change slot, then nbits data MSB first, then padding when the word is complete
    task automatic send_word(input logic w, input logic [DB-1:0] data, input int nbits);
        send_slot(w, 1'b0);
        for (int i = 0; i < nbits; i++) send_slot(w, data[DB-1-i]);
        if (nbits == DB) for (int i = 0; i < 7; i++) send_slot(w, 1'b0);
    endtask

    task automatic send_pair(input logic [DB-1:0] l, input logic [DB-1:0] r);
        send_word(1'b0, l, DB);
        send_word(1'b1, r, DB);
    endtask

    task automatic pulse_clken();
        @(negedge clock) clken48kHz = 1'b1;
        @(negedge clock) clken48kHz = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clock) err_clr = 1'b1;
        @(negedge clock) err_clr = 1'b0;
    endtask

    // right word whose final bit latches in the same cycle as a clken48kHz pulse
    task automatic send_right_with_clken(input logic [DB-1:0] data);
        send_slot(1'b1, 1'b0);
        for (int i = 0; i < DB - 1; i++) send_slot(1'b1, data[DB-1-i]);
        sd = data[0];
        repeat (5) @(negedge clock);
        sck = 1'b1;
        repeat (2) @(negedge clock);
        clken48kHz = 1'b1;
        @(negedge clock) clken48kHz = 1'b0;
        repeat (2) @(negedge clock);
        sck = 1'b0;
        for (int i = 0; i < 7; i++) send_slot(1'b1, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_out("rst", 32'h0, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // right-channel padding before the first left word: no capture yet
        send_word(1'b1, 24'hFFFFFF, DB);
        send_pair(24'h123456, 24'hEDCBAA);
        check("pre_clken_valid", {31'd0, valid}, 32'd0);
        pulse_clken();
        check_out("basic", 32'h048D1, EXP_R1);
        check("basic_valid", {31'd0, valid}, 32'd1);
        check("basic_overrun", {31'd0, overrun}, 32'd0);
        check("basic_frame_err", {31'd0, frame_err}, 32'd0);

        send_pair(24'h7FFFFF, 24'h000020);
        pulse_clken();
        check_out("maxpos", 32'h1FFFF, EXP_R2);

        send_pair(24'h000000, 24'hFFFFFF);
        pulse_clken();
        check_out("minus1", 32'h00000, EXP_R3);
        check("minus1_underrun", {31'd0, underrun}, 32'd0);

        send_pair(24'h100000, 24'h200000);
        send_pair(24'h400000, 24'hC00000);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        pulse_clken();
        check_out("ovr", 32'h10000, 32'h30000);
        pulse_clr();
        check("ovr_clr", {31'd0, overrun}, 32'd0);

        pulse_clken();
        pulse_clken();
        check("udr_set", {31'd0, underrun}, 32'd1);
        check_out("udr", 32'h10000, 32'h30000);
        @(negedge clock) begin clken48kHz = 1'b1; err_clr = 1'b1; end
        @(negedge clock) begin clken48kHz = 1'b0; err_clr = 1'b0; end
        check("udr_clr_race", {31'd0, underrun}, 32'd1);
        pulse_clr();
        check("udr_clr", {31'd0, underrun}, 32'd0);

        send_word(1'b0, 24'hFFFFFF, 10);
        send_word(1'b1, 24'h000040, DB);
        check("frm_set", {31'd0, frame_err}, 32'd1);
        pulse_clken();
        send_pair(24'h0ABCC0, 24'hF00000);
        pulse_clken();
        check_out("frm_next", 32'h02AF3, 32'h3C000);
        check("frm_overrun", {31'd0, overrun}, 32'd0);
        pulse_clr();
        check("frm_clr", {31'd0, frame_err}, 32'd0);

        send_pair(24'h200000, 24'h300000);
        send_word(1'b0, 24'h040000, DB);
        send_right_with_clken(24'hFC0000);
        check_out("same_cyc", 32'h08000, 32'h0C000);
        check("same_cyc_overrun", {31'd0, overrun}, 32'd0);
        pulse_clken();
        check_out("same_cyc_next", 32'h01000, 32'h3F000);
        check("same_cyc_underrun", {31'd0, underrun}, 32'd0);

        send_word(1'b0, 24'h5A5A5A, 10);
        @(negedge clock) reset = 1'b0;
        repeat (3) @(negedge clock);
        check_out("midrst", 32'h0, 32'h0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_state", {30'd0, dut.state}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 14 + 7; i++) send_slot(1'b0, 1'b1);
        send_word(1'b1, 24'h123440, DB);
        pulse_clken();
        check_out("post_rst", 32'h00000, 32'h048D1);
        check("post_rst_valid", {31'd0, valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
